// File: rtl/pc_unit_if.sv
// Program-counter unit bus: next-PC/control inputs toward the unit and fetch-side
// outputs back to the pipeline.
// Optional macro PC_UNIT_RETIRE_CNT_EN adds the 64-bit retire_cnt signal.
interface pc_unit_if #(
  parameter int unsigned W = 32
);
  logic [W-1:0] pc_next;
  logic         stall;
  logic         trap_clr;
  logic [W-1:0] pc;
  logic [W-1:0] pc_plus4;
  logic         fetch_valid;
  logic         trap;
  logic [W-1:0] trap_pc;
`ifdef PC_UNIT_RETIRE_CNT_EN
  logic [63:0]  retire_cnt;

  modport master (
    output pc_next, stall, trap_clr,
    input  pc, pc_plus4, fetch_valid, trap, trap_pc, retire_cnt
  );
  modport slave (
    input  pc_next, stall, trap_clr,
    output pc, pc_plus4, fetch_valid, trap, trap_pc, retire_cnt
  );
`else
  modport master (
    output pc_next, stall, trap_clr,
    input  pc, pc_plus4, fetch_valid, trap, trap_pc
  );
  modport slave (
    input  pc_next, stall, trap_clr,
    output pc, pc_plus4, fetch_valid, trap, trap_pc
  );
`endif
endinterface

// File: rtl/pc_unit.sv
// Program counter unit: BOOT -> RUN sequencing, aligned next-PC loading, sticky trap on
// a misaligned target, trap_clr restart from RESET_VECTOR.
// Optional macro PC_UNIT_RETIRE_CNT_EN adds a 64-bit retired-fetch counter.
module pc_unit #(
  parameter int unsigned   W            = 32,
  parameter logic [W-1:0]  RESET_VECTOR = '0
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_unit_if.slave bus
);

  typedef enum logic [1:0] {StBoot, StRun, StTrap} state_e;

  state_e       state_q;
  logic [W-1:0] pc_q;
  logic [W-1:0] trap_pc_q;
  logic         trap_q;
  logic         fetch_valid_q;
  logic         misaligned;
`ifdef PC_UNIT_RETIRE_CNT_EN
  logic [63:0]  retire_cnt_q;
`endif

  // A target whose low two bits are non-zero is not a legal word fetch address.
  assign misaligned = |bus.pc_next[1:0];

  // Single FSM register block; fetch_valid is registered alongside the state it mirrors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= RESET_VECTOR;
      trap_q        <= 1'b0;
      trap_pc_q     <= '0;
      fetch_valid_q <= 1'b0;
`ifdef PC_UNIT_RETIRE_CNT_EN
      retire_cnt_q  <= '0;
`endif
    end else if (bus.trap_clr) begin
      // Restart wins over stall and the alignment check; retire count survives.
      state_q       <= StBoot;
      pc_q          <= RESET_VECTOR;
      trap_q        <= 1'b0;
      trap_pc_q     <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StBoot: begin
          state_q       <= StRun;
          fetch_valid_q <= 1'b1;
        end
        StRun: begin
          if (!bus.stall) begin
            if (misaligned) begin
              state_q       <= StTrap;
              trap_q        <= 1'b1;
              trap_pc_q     <= bus.pc_next;
              fetch_valid_q <= 1'b0;
            end else begin
              pc_q          <= bus.pc_next;
`ifdef PC_UNIT_RETIRE_CNT_EN
              retire_cnt_q  <= retire_cnt_q + 64'd1;
`endif
            end
          end
        end
        StTrap: begin
          // Sticky until trap_clr or reset.
        end
        default: begin
          state_q       <= StBoot;
          pc_q          <= RESET_VECTOR;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are straight from registers, except the wrapping PC+4 adder.
  always_comb begin
    bus.pc          = pc_q;
    bus.pc_plus4    = pc_q + W'(4);
    bus.fetch_valid = fetch_valid_q;
    bus.trap        = trap_q;
    bus.trap_pc     = trap_pc_q;
`ifdef PC_UNIT_RETIRE_CNT_EN
    bus.retire_cnt  = retire_cnt_q;
`endif
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic against a
// behavioural model of the PC rules.
module tb_pc_unit;
  localparam int unsigned  W  = 32;
  localparam logic [W-1:0] RV = 32'h0000_0040;

  localparam int MBoot = 0;
  localparam int MRun  = 1;
  localparam int MTrap = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pc_unit_if #(.W(W)) bus ();

  pc_unit #(
    .W           (W),
    .RESET_VECTOR(RV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  int           m_st;
  logic [W-1:0] m_pc;
  logic [W-1:0] m_tpc;
  bit           m_trap;
  logic [63:0]  m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st   = MBoot;
    m_pc   = RV;
    m_tpc  = '0;
    m_trap = 1'b0;
    m_cnt  = '0;
  endtask

  // Applies one clock edge worth of rules to the model.
  task automatic model_edge(input logic [W-1:0] nx, input bit st, input bit clr);
    if (clr) begin
      m_st   = MBoot;
      m_pc   = RV;
      m_trap = 1'b0;
      m_tpc  = '0;
    end else if (m_st == MBoot) begin
      m_st = MRun;
    end else if (m_st == MRun && !st) begin
      if ((nx % 4) != 0) begin
        m_st   = MTrap;
        m_trap = 1'b1;
        m_tpc  = nx;
      end else begin
        m_pc  = nx;
        m_cnt = m_cnt + 64'd1;
      end
    end
  endtask

  task automatic check_all(input string where);
    logic [63:0] sum;
    sum = (64'(m_pc) + 64'd4) % (64'd1 << W);
    check({where, ".pc"}, 64'(bus.pc), 64'(m_pc));
    check({where, ".pc_plus4"}, 64'(bus.pc_plus4), sum);
    check({where, ".fetch_valid"}, 64'(bus.fetch_valid), 64'(m_st == MRun));
    check({where, ".trap"}, 64'(bus.trap), 64'(m_trap));
    check({where, ".trap_pc"}, 64'(bus.trap_pc), 64'(m_tpc));
`ifdef PC_UNIT_RETIRE_CNT_EN
    check({where, ".retire_cnt"}, bus.retire_cnt, m_cnt);
`endif
  endtask

  // Drive inputs, take one edge, sample 1ns later.
  task automatic cyc(input logic [W-1:0] nx, input bit st, input bit clr, input string where);
    bus.pc_next  = nx;
    bus.stall    = st;
    bus.trap_clr = clr;
    @(posedge clk);
    model_edge(nx, st, clr);
    #1;
    check_all(where);
  endtask

  // Pull reset between edges and confirm it acts without a clock.
  task automatic async_reset(input string where);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check({where, ".async_pc"}, 64'(bus.pc), 64'(RV));
    check_all(where);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  logic [W-1:0] nx;
  logic [63:0]  cnt0;

  initial begin
    bus.pc_next  = '0;
    bus.stall    = 1'b0;
    bus.trap_clr = 1'b0;
    model_reset();
    #12;
    check("reset.pc", 64'(bus.pc), 64'(RV));
    check("reset.fetch_valid", 64'(bus.fetch_valid), 64'd0);
    check("reset.trap", 64'(bus.trap), 64'd0);
    check("reset.trap_pc", 64'(bus.trap_pc), 64'd0);
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("release");

    // Sequential fetch from reset: RV, RV, RV+4, RV+8, RV+12
    for (int i = 0; i < 4; i++) begin
      cyc(bus.pc_plus4, 1'b0, 1'b0, "seq");
      check("seq.pc_lit", 64'(bus.pc), 64'(RV + W'(i == 0 ? 0 : 4 * i)));
      check("seq.fv_lit", 64'(bus.fetch_valid), 64'd1);
    end

    // Branch held off by stall
    cyc(32'h10, 1'b0, 1'b0, "br_setup");
    cnt0 = m_cnt;
    for (int i = 0; i < 2; i++) begin
      cyc(32'h80, 1'b1, 1'b0, "br_stall");
      check("br_stall.pc_lit", 64'(bus.pc), 64'h10);
    end
    cyc(32'h80, 1'b0, 1'b0, "br_take");
    check("br_take.pc_lit", 64'(bus.pc), 64'h80);
`ifdef PC_UNIT_RETIRE_CNT_EN
    check("br_take.cnt_step", bus.retire_cnt, cnt0 + 64'd1);
`endif

    // Misaligned target enters a sticky trap
    cyc(32'h20, 1'b0, 1'b0, "mis_setup");
    cyc(32'h26, 1'b0, 1'b0, "mis");
    check("mis.trap_lit", 64'(bus.trap), 64'd1);
    check("mis.trap_pc_lit", 64'(bus.trap_pc), 64'h26);
    check("mis.pc_lit", 64'(bus.pc), 64'h20);
    check("mis.fv_lit", 64'(bus.fetch_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(W'($urandom), 1'($urandom), 1'b0, "trap_hold");
      check("trap_hold.pc_lit", 64'(bus.pc), 64'h20);
      check("trap_hold.trap_pc_lit", 64'(bus.trap_pc), 64'h26);
    end

    // trap_clr beats stall
    cyc(32'h0000_0104, 1'b1, 1'b1, "clr");
    check("clr.pc_lit", 64'(bus.pc), 64'(RV));
    check("clr.trap_lit", 64'(bus.trap), 64'd0);
    check("clr.trap_pc_lit", 64'(bus.trap_pc), 64'd0);
    check("clr.fv_lit", 64'(bus.fetch_valid), 64'd0);
    cyc(32'h0000_0200, 1'b0, 1'b0, "clr_boot");
    check("clr_boot.fv_lit", 64'(bus.fetch_valid), 64'd1);
    check("clr_boot.pc_lit", 64'(bus.pc), 64'(RV));

    // PC+4 wrap and asynchronous reset
    cyc(32'hFFFF_FFFC, 1'b0, 1'b0, "wrap_setup");
    check("wrap.pc_plus4_lit", 64'(bus.pc_plus4), 64'd0);
    cyc(bus.pc_plus4, 1'b0, 1'b0, "wrap_load");
    check("wrap_load.pc_lit", 64'(bus.pc), 64'd0);
    check("wrap_load.trap_lit", 64'(bus.trap), 64'd0);
    cyc(32'hFFFF_FFFC, 1'b0, 1'b0, "ar_setup");
    async_reset("ar");
    cyc(32'h0000_0300, 1'b0, 1'b0, "ar_boot");
    check("ar_boot.fv_lit", 64'(bus.fetch_valid), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      int unsigned k;
      k  = $urandom % 8;
      nx = W'($urandom);
      if (k < 4)      nx = bus.pc_plus4;
      else if (k < 6) nx[1:0] = 2'b00;
      else if (k < 7) nx[1:0] = 2'($urandom_range(1, 3));
      if (($urandom % 150) == 0) begin
        async_reset("rnd_ar");
      end else begin
        cyc(nx, ($urandom % 4) == 0, ($urandom % 100) < 4, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
